// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass and a
// per-register busy scoreboard. Decode reads operands and reserves
// destinations; writeback writes results and releases reservations.
//
// Handshake: RF_W and rsv_valid are valid-only strobes with no ready.
// Every request qualified by RF_ena (and not aimed at a hardwired zero
// register) is accepted at the next rising edge of RF_clk.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    RF_clk,
  input  logic                    RF_rst_n,
  input  logic                    RF_ena,
  input  logic                    RF_W,
  input  logic [ADDR_W-1:0]       Rdc,
  input  logic [DATA_W-1:0]       Rd,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]    busy_vec,
  output logic [ADDR_W:0]         busy_cnt,
  output logic                    rsv_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  logic             wa;
  logic             ra;
  logic             same_idx;
  logic             set_new;
  logic             clr_old;
  logic             err_nxt;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Accepted write / reservation: gated by enable, register 0 is inert when hardwired.
  assign wa = RF_ena && RF_W && !(ZERO_EN && (Rdc == '0));
  assign ra = RF_ena && rsv_valid && !(ZERO_EN && (rsv_addr == '0));

  // A same-index write and reservation means the old producer retires while
  // a new one claims the register, so the bit stays set and nothing is counted.
  assign same_idx = wa && ra && (Rdc == rsv_addr);
  assign set_new  = ra && !busy_vec[rsv_addr];
  assign clr_old  = wa && busy_vec[Rdc] && !same_idx;
  assign err_nxt  = ra && busy_vec[rsv_addr] && !same_idx;

  // Next scoreboard: clear on writeback, then set on reservation so set wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (wa) busy_nxt[Rdc] = 1'b0;
    if (ra) busy_nxt[rsv_addr] = 1'b1;
  end

  // Incremental population count tracking busy_nxt without a popcount tree.
  always_comb begin
    cnt_nxt = busy_cnt;
    if (set_new && !clr_old) cnt_nxt = busy_cnt + CNT_ONE;
    else if (!set_new && clr_old) cnt_nxt = busy_cnt - CNT_ONE;
  end

  // Register storage: one write per cycle, cleared by reset.
  always_ff @(posedge RF_clk or negedge RF_rst_n) begin
    if (!RF_rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wa) begin
      mem[Rdc] <= Rd;
    end
  end

  // Scoreboard bits, busy count and the double-reservation pulse.
  always_ff @(posedge RF_clk or negedge RF_rst_n) begin
    if (!RF_rst_n) begin
      busy_vec <= '0;
      busy_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
      rsv_err  <= err_nxt;
    end
  end

  // Read ports: disabled/zero register read 0, then bypass, then storage.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [ADDR_W-1:0] idx;
      idx = rd_addr[i*ADDR_W +: ADDR_W];
      if (!RF_ena) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (ZERO_EN && (idx == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (BYPASS_EN && wa && (idx == Rdc)) begin
        rd_data[i*DATA_W +: DATA_W] = Rd;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = mem[idx];
        rd_busy[i] = busy_vec[idx];
      end
    end
  end

endmodule
